// File: rtl/alu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// alu_ctrl_fsm
// Multi-cycle control unit for the 16-bit RISC core. Each instruction walks
// through FETCH -> DECODE -> EXEC -> MEM -> WB (skipping what it does not need).
// The datapath owns the PC, register file and ALU; this block only steers them.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_req / instr_valid  instruction fetch handshake, instr is the fetched word
//   ir                       registered instruction register
//   pc_inc, pc_branch        one-cycle PC update pulses (fetch / taken branch)
//   alu_ctrl, alu_src_imm    ALU operation and B-operand select
//   alu_zero                 ALU zero flag (branch compare result)
//   mem_req/mem_we/mem_ready data memory handshake
//   reg_we, wb_sel           register writeback enable and source (0 ALU, 1 mem)
//   illegal                  one-cycle pulse while decoding an undefined opcode
//   bus_error                sticky handshake-timeout flag
//   halted                   high while parked in HALT
// -----------------------------------------------------------------------------
module alu_ctrl_fsm #(
   parameter int MAX_WAIT = 255,
   parameter int WAIT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic        instr_req,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic [15:0] ir,
   output logic        pc_inc,
   output logic        pc_branch,
   output logic [2:0]  alu_ctrl,
   output logic        alu_src_imm,
   input  logic        alu_zero,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        illegal,
   output logic        bus_error,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MUL  = 4'h1;
   localparam logic [3:0] OP_SHL  = 4'h2;
   localparam logic [3:0] OP_XOR  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LW   = 4'h6;
   localparam logic [3:0] OP_SW   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_MUL = 3'b001;
   localparam logic [2:0] ALU_SHL = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;

   // The counter starts at 0 on state entry, so the last allowed waiting cycle
   // is the one where it holds MAX_WAIT-1 (MAX_WAIT waiting cycles in total).
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   // All level outputs that depend only on (state, opcode), kept in one register.
   typedef struct packed {
      logic       instr_req;
      logic [2:0] alu_ctrl;
      logic       alu_src_imm;
      logic       mem_req;
      logic       mem_we;
      logic       reg_we;
      logic       wb_sel;
      logic       halted;
   } ctrl_t;

   state_t            state_r;
   logic [15:0]       ir_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   ctrl_t             ctrl_r;
   logic              illegal_r;
   logic              bus_error_r;
   logic [3:0]        op_s;

   assign op_s = ir_r[15:12];

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'h9) && (op <= 4'hE);
   endfunction

   // {alu_ctrl, alu_src_imm} used in EXEC and held through WB.
   function automatic logic [3:0] exec_alu(input logic [3:0] op);
      logic [3:0] r;
      case (op)
         OP_MUL:                r = {ALU_MUL, 1'b0};
         OP_SHL:                r = {ALU_SHL, 1'b0};
         OP_XOR:                r = {ALU_XOR, 1'b0};
         OP_ADD:                r = {ALU_ADD, 1'b0};
         OP_ADDI, OP_LW, OP_SW: r = {ALU_ADD, 1'b1};
         OP_BEQ:                r = {ALU_XOR, 1'b0};
         default:               r = {ALU_ADD, 1'b0};
      endcase
      return r;
   endfunction

   // Output values to present while sitting in state s with opcode op.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] op);
      ctrl_t c;
      c          = '0;
      c.alu_ctrl = ALU_ADD;
      case (s)
         S_FETCH:  c.instr_req = 1'b1;
         S_DECODE: c.instr_req = 1'b0;
         S_EXEC:   {c.alu_ctrl, c.alu_src_imm} = exec_alu(op);
         S_MEM: begin
            // Address operands stay on the ALU for the whole access.
            c.mem_req     = 1'b1;
            c.mem_we      = (op == OP_SW);
            c.alu_src_imm = 1'b1;
         end
         S_WB: begin
            c.reg_we = 1'b1;
            c.wb_sel = (op == OP_LW);
            {c.alu_ctrl, c.alu_src_imm} = exec_alu(op);
         end
         S_HALT:   c.halted = 1'b1;
         default:  c.instr_req = 1'b0;
      endcase
      return c;
   endfunction

   // Control FSM: state, instruction register, wait counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_FETCH;
         ir_r        <= 16'h0000;
         wait_cnt_r  <= '0;
         bus_error_r <= 1'b0;
         illegal_r   <= 1'b0;
         ctrl_r      <= ctrl_for(S_FETCH, OP_NOP);
      end else begin
         // Pulses and the counter drop back unless a branch below keeps them.
         illegal_r  <= 1'b0;
         wait_cnt_r <= '0;
         case (state_r)
            S_FETCH: begin
               if (instr_valid) begin
                  ir_r      <= instr;
                  illegal_r <= is_illegal(instr[15:12]);
                  state_r   <= S_DECODE;
                  ctrl_r    <= ctrl_for(S_DECODE, instr[15:12]);
               end else if (wait_cnt_r == WAIT_LAST) begin
                  bus_error_r <= 1'b1;
                  state_r     <= S_HALT;
                  ctrl_r      <= ctrl_for(S_HALT, op_s);
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               case (op_s)
                  OP_NOP: begin
                     state_r <= S_FETCH;
                     ctrl_r  <= ctrl_for(S_FETCH, op_s);
                  end
                  OP_HALT: begin
                     state_r <= S_HALT;
                     ctrl_r  <= ctrl_for(S_HALT, op_s);
                  end
                  OP_MUL, OP_SHL, OP_XOR, OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
                     state_r <= S_EXEC;
                     ctrl_r  <= ctrl_for(S_EXEC, op_s);
                  end
                  default: begin
                     // Undefined opcode: pulse already raised on DECODE entry.
                     state_r <= S_FETCH;
                     ctrl_r  <= ctrl_for(S_FETCH, op_s);
                  end
               endcase
            end
            S_EXEC: begin
               case (op_s)
                  OP_LW, OP_SW: begin
                     state_r <= S_MEM;
                     ctrl_r  <= ctrl_for(S_MEM, op_s);
                  end
                  OP_BEQ: begin
                     state_r <= S_FETCH;
                     ctrl_r  <= ctrl_for(S_FETCH, op_s);
                  end
                  default: begin
                     state_r <= S_WB;
                     ctrl_r  <= ctrl_for(S_WB, op_s);
                  end
               endcase
            end
            S_MEM: begin
               // Completion is checked before the timeout so a late ready still wins.
               if (mem_ready) begin
                  if (op_s == OP_LW) begin
                     state_r <= S_WB;
                     ctrl_r  <= ctrl_for(S_WB, op_s);
                  end else begin
                     state_r <= S_FETCH;
                     ctrl_r  <= ctrl_for(S_FETCH, op_s);
                  end
               end else if (wait_cnt_r == WAIT_LAST) begin
                  bus_error_r <= 1'b1;
                  state_r     <= S_HALT;
                  ctrl_r      <= ctrl_for(S_HALT, op_s);
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
               end
            end
            S_WB: begin
               state_r <= S_FETCH;
               ctrl_r  <= ctrl_for(S_FETCH, op_s);
            end
            S_HALT: begin
               state_r <= S_HALT;
               ctrl_r  <= ctrl_for(S_HALT, op_s);
            end
            default: begin
               state_r <= S_FETCH;
               ctrl_r  <= ctrl_for(S_FETCH, op_s);
            end
         endcase
      end
   end

   // PC pulses must coincide with the handshake / compare cycle itself, so they
   // are decoded from the registered state and the qualifying input.
   assign pc_inc    = !rst && (state_r == S_FETCH) && instr_valid;
   assign pc_branch = !rst && (state_r == S_EXEC) && (op_s == OP_BEQ) && alu_zero;

   assign instr_req   = ctrl_r.instr_req;
   assign alu_ctrl    = ctrl_r.alu_ctrl;
   assign alu_src_imm = ctrl_r.alu_src_imm;
   assign mem_req     = ctrl_r.mem_req;
   assign mem_we      = ctrl_r.mem_we;
   assign reg_we      = ctrl_r.reg_we;
   assign wb_sel      = ctrl_r.wb_sel;
   assign halted      = ctrl_r.halted;
   assign ir          = ir_r;
   assign illegal     = illegal_r;
   assign bus_error   = bus_error_r;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_fsm
// Random instruction stream with a per-instruction reference model. The driver
// pushes the predicted per-instruction record when it hands an instruction to
// the DUT; an independent monitor rebuilds the record from the DUT pins and
// compares. Directed sections cover reset, fetch timeout and reset during MEM.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] ir;
   logic        pc_inc;
   logic        pc_branch;
   logic [2:0]  alu_ctrl;
   logic        alu_src_imm;
   logic        alu_zero;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ready;
   logic        reg_we;
   logic        wb_sel;
   logic        illegal;
   logic        bus_error;
   logic        halted;

   always #5 clk = ~clk;

   alu_ctrl_fsm #(.MAX_WAIT(255), .WAIT_W(8)) dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_valid(instr_valid), .instr(instr), .ir(ir),
      .pc_inc(pc_inc), .pc_branch(pc_branch),
      .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .alu_zero(alu_zero),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
      .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal),
      .bus_error(bus_error), .halted(halted)
   );

   // Observable summary of one instruction, from its fetch handshake cycle up to
   // (not including) the next FETCH cycle, or up to the first HALT cycle.
   typedef struct {
      int          cycles;
      int          n_inc;
      int          n_br;
      int          n_ill;
      int          n_we;
      int          n_mem;
      logic [15:0] ir;
      logic        wb_sel;
      logic [3:0]  wb_alu;    // {alu_ctrl, alu_src_imm} during reg_we
      logic        mem_we;
      logic [3:0]  mem_alu;   // {alu_ctrl, alu_src_imm} during mem_req
      logic [3:0]  exec_alu;  // {alu_ctrl, alu_src_imm} in the third cycle
      logic        halted;
   } rec_t;

   rec_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_rec    = 0;
   bit   mon_en   = 1'b0;

   localparam int NDIR  = 7;
   localparam int NRAND = 120;
   logic [15:0] dir_ins [NDIR] = '{16'h4123, 16'h812F, 16'h812F, 16'h6345, 16'h7345, 16'hA000, 16'h0000};
   int          dir_z   [NDIR] = '{0, 1, 0, 0, 0, 0, 0};
   int          dir_mw  [NDIR] = '{0, 0, 0, 3, 1, 0, 0};

   task automatic chk_eq(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: what one instruction should look like from the outside, given
   // the zero flag it sees and how many cycles memory stalls it.
   function automatic rec_t model(input logic [15:0] ins, input logic z, input int mw);
      rec_t r;
      logic [3:0] op;
      op = ins[15:12];
      r.cycles = 2; r.n_inc = 1; r.n_br = 0; r.n_ill = 0; r.n_we = 0; r.n_mem = 0;
      r.ir = ins; r.wb_sel = 1'b0; r.wb_alu = 4'h0; r.mem_we = 1'b0; r.mem_alu = 4'h0;
      r.exec_alu = 4'b1000; r.halted = 1'b0;
      case (op)
         4'h0: r.cycles = 2;
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            r.cycles = 4;
            r.n_we   = 1;
            case (op)
               4'h1:    r.exec_alu = {3'b001, 1'b0};
               4'h2:    r.exec_alu = {3'b010, 1'b0};
               4'h3:    r.exec_alu = {3'b011, 1'b0};
               4'h4:    r.exec_alu = {3'b100, 1'b0};
               default: r.exec_alu = {3'b100, 1'b1};
            endcase
            r.wb_alu = r.exec_alu;
         end
         4'h6: begin
            r.cycles = 5 + mw; r.exec_alu = {3'b100, 1'b1};
            r.n_mem = mw + 1; r.mem_alu = {3'b100, 1'b1};
            r.n_we = 1; r.wb_sel = 1'b1; r.wb_alu = {3'b100, 1'b1};
         end
         4'h7: begin
            r.cycles = 4 + mw; r.exec_alu = {3'b100, 1'b1};
            r.n_mem = mw + 1; r.mem_we = 1'b1; r.mem_alu = {3'b100, 1'b1};
         end
         4'h8: begin
            r.cycles = 3; r.exec_alu = {3'b011, 1'b0}; r.n_br = z ? 1 : 0;
         end
         4'hF: r.halted = 1'b1;
         default: r.n_ill = 1;
      endcase
      return r;
   endfunction

   task automatic compare_rec(input rec_t g);
      rec_t  e;
      string p;
      p = $sformatf("rec%0d_", n_rec);
      n_rec++;
      chk_eq({p, "queue_nonempty"}, int'(sb.size() > 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk_eq({p, "cycles"},   g.cycles,   e.cycles);
      chk_eq({p, "pc_inc"},   g.n_inc,    e.n_inc);
      chk_eq({p, "pc_branch"},g.n_br,     e.n_br);
      chk_eq({p, "illegal"},  g.n_ill,    e.n_ill);
      chk_eq({p, "reg_we"},   g.n_we,     e.n_we);
      chk_eq({p, "mem_req"},  g.n_mem,    e.n_mem);
      chk_eq({p, "ir"},       g.ir,       e.ir);
      chk_eq({p, "wb_sel"},   g.wb_sel,   e.wb_sel);
      chk_eq({p, "wb_alu"},   g.wb_alu,   e.wb_alu);
      chk_eq({p, "mem_we"},   g.mem_we,   e.mem_we);
      chk_eq({p, "mem_alu"},  g.mem_alu,  e.mem_alu);
      chk_eq({p, "exec_alu"}, g.exec_alu, e.exec_alu);
      chk_eq({p, "halted"},   g.halted,   e.halted);
   endtask

   // Monitor: rebuilds per-instruction records from the pins, mid-cycle.
   rec_t mon_got;
   bit   mon_active = 1'b0;
   int   mon_idx    = 0;
   initial begin : monitor
      forever begin
         @(negedge clk);
         #3;
         if (!mon_en) begin
            mon_active = 1'b0;
         end else begin
            if (mon_active && (instr_req || halted)) begin
               mon_got.halted = halted;
               compare_rec(mon_got);
               mon_active = 1'b0;
            end
            if (instr_req && instr_valid) begin
               mon_active = 1'b1;
               mon_idx    = 0;
               mon_got.cycles = 0; mon_got.n_inc = 0; mon_got.n_br = 0; mon_got.n_ill = 0;
               mon_got.n_we = 0; mon_got.n_mem = 0; mon_got.ir = 16'h0000; mon_got.wb_sel = 1'b0;
               mon_got.wb_alu = 4'h0; mon_got.mem_we = 1'b0; mon_got.mem_alu = 4'h0;
               mon_got.exec_alu = 4'b1000; mon_got.halted = 1'b0;
            end
            if (mon_active) begin
               mon_got.cycles++;
               if (pc_inc)    mon_got.n_inc++;
               if (pc_branch) mon_got.n_br++;
               if (illegal)   mon_got.n_ill++;
               if (mon_idx == 1) mon_got.ir = ir;
               if (mon_idx == 2) mon_got.exec_alu = {alu_ctrl, alu_src_imm};
               if (reg_we) begin
                  mon_got.n_we++;
                  mon_got.wb_sel = wb_sel;
                  mon_got.wb_alu = {alu_ctrl, alu_src_imm};
               end
               if (mem_req) begin
                  mon_got.n_mem++;
                  mon_got.mem_we  = mem_we;
                  mon_got.mem_alu = {alu_ctrl, alu_src_imm};
               end
               mon_idx++;
            end
         end
      end
   end

   // Leaves the caller at a falling edge with rst just released.
   task automatic do_reset(input bit check);
      @(negedge clk);
      rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      if (check) begin
         chk_eq("rst_mem_req",     mem_req,     0);
         chk_eq("rst_mem_we",      mem_we,      0);
         chk_eq("rst_reg_we",      reg_we,      0);
         chk_eq("rst_wb_sel",      wb_sel,      0);
         chk_eq("rst_illegal",     illegal,     0);
         chk_eq("rst_pc_inc",      pc_inc,      0);
         chk_eq("rst_pc_branch",   pc_branch,   0);
         chk_eq("rst_bus_error",   bus_error,   0);
         chk_eq("rst_halted",      halted,      0);
         chk_eq("rst_ir",          ir,          0);
         chk_eq("rst_alu_ctrl",    alu_ctrl,    4);
         chk_eq("rst_alu_src_imm", alu_src_imm, 0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [15:0] cur;
      int          cur_z, cur_mw, fwait, mwait, n_issued, nreq;
      bit          pending, seen;

      rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; alu_zero = 1'b0; mem_ready = 1'b0;
      cur = 16'h0000; cur_z = 0; cur_mw = 0; fwait = 0; mwait = 0; n_issued = 0; pending = 1'b0;

      do_reset(1'b1);

      // ---- random program, ends with HALT ----
      mon_en = 1'b1;
      for (int cyc = 0; cyc < 20000 && !halted; cyc++) begin
         if (instr_req) begin
            if (!pending) begin
               if (n_issued < NDIR) begin
                  cur = dir_ins[n_issued]; cur_z = dir_z[n_issued]; cur_mw = dir_mw[n_issued]; fwait = 0;
               end else if (n_issued < NDIR + NRAND) begin
                  cur    = {4'($urandom_range(0, 14)), 12'($urandom)};
                  cur_z  = int'($urandom_range(0, 1));
                  cur_mw = int'($urandom_range(0, 4));
                  fwait  = int'($urandom_range(0, 3));
               end else begin
                  cur = 16'hF000; cur_z = 0; cur_mw = 0; fwait = 0;
               end
               pending = 1'b1;
            end
            if (fwait > 0) begin
               instr_valid = 1'b0; instr = 16'($urandom); fwait--;
            end else begin
               instr_valid = 1'b1; instr = cur; alu_zero = cur_z[0]; mwait = cur_mw;
               sb.push_back(model(cur, cur_z[0], cur_mw));
               pending = 1'b0;
               n_issued++;
            end
         end else begin
            // Handshake inputs outside their wait state must be ignored.
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
         end
         if (mem_req) begin
            if (mwait > 0) begin
               mem_ready = 1'b0; mwait--;
            end else begin
               mem_ready = 1'b1;
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      chk_eq("halt_reached", halted, 1);
      for (int i = 0; i < 20; i++) begin
         instr_valid = 1'($urandom_range(0, 1));
         mem_ready   = 1'($urandom_range(0, 1));
         #3;
         chk_eq($sformatf("halt_hold_req_%0d", i), instr_req, 0);
         chk_eq($sformatf("halt_hold_halted_%0d", i), halted, 1);
         @(negedge clk);
      end
      mon_en = 1'b0;
      chk_eq("scoreboard_drained", sb.size(), 0);
      chk_eq("records_seen", n_rec, n_issued);

      // ---- fetch timeout ----
      do_reset(1'b0);
      nreq = 0; seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         #3;
         if (bus_error) begin
            seen = 1'b1;
         end else begin
            if (instr_req) nreq++;
            @(negedge clk);
         end
      end
      chk_eq("timeout_bus_error", seen, 1);
      chk_eq("timeout_req_cycles", nreq, 255);
      chk_eq("timeout_halted", halted, 1);
      chk_eq("timeout_no_req", instr_req, 0);

      do_reset(1'b0);
      #3;
      chk_eq("rst_clears_bus_error", bus_error, 0);
      chk_eq("rst_leaves_halt", halted, 0);
      chk_eq("rst_back_to_fetch", instr_req, 1);

      // ---- reset during SW memory wait ----
      @(negedge clk);
      instr_valid = 1'b1; instr = 16'h7345; mem_ready = 1'b0;
      @(negedge clk);
      instr_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         #3;
         if (mem_req) seen = 1'b1;
         else @(negedge clk);
      end
      chk_eq("sw_mem_reached", seen, 1);
      chk_eq("sw_mem_we", mem_we, 1);
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      #3;
      chk_eq("midrst_mem_req", mem_req, 0);
      chk_eq("midrst_reg_we", reg_we, 0);
      chk_eq("midrst_ir", ir, 0);
      rst = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      #3;
      chk_eq("midrst_fetch", instr_req, 1);
      chk_eq("midrst_no_mem", mem_req, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
